iram_loader: RTL and testbench



---
 rtl/iram_loader_pkg.sv | 33 +++
 rtl/iram_loader_timeout.sv | 39 +++
 rtl/iram_loader.sv | 204 ++++++++++++++++++++
 tb/tb_iram_loader.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iram_loader_pkg.sv
// Shared types and constants for the instruction RAM bootloader.
// IRAM_LOADER_CHECKSUM_EN adds the trailing checksum state.
package iram_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Byte offsets within a frame; the header states reuse them as their encoding.
    localparam int OFS_SYNC   = 0;
    localparam int OFS_ADDR_H = 1;
    localparam int OFS_ADDR_L = 2;
    localparam int OFS_CNT_H  = 3;
    localparam int OFS_CNT_L  = 4;
    localparam int OFS_DATA   = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'(OFS_SYNC),
        ST_ADDR_H = 3'(OFS_ADDR_H),
        ST_ADDR_L = 3'(OFS_ADDR_L),
        ST_CNT_H  = 3'(OFS_CNT_H),
        ST_CNT_L  = 3'(OFS_CNT_L),
        ST_DATA_H = 3'(OFS_DATA),
        ST_DATA_L = 3'(OFS_DATA + 1)
`ifdef IRAM_LOADER_CHECKSUM_EN
        ,
        ST_CSUM   = 3'(OFS_DATA + 2)
`endif
    } state_t;

    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

endpackage

// File: rtl/iram_loader_timeout.sv
// Inter-byte gap counter: counts idle cycles while enabled, flags the final allowed cycle.
// Saturates at its terminal value so a held enable cannot wrap it.
module loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] gap_q;
    logic [CW-1:0] gap_d;

    always_comb begin
        gap_d = gap_q;
        if (!enable || clear) begin
            gap_d = '0;
        end else if (gap_q != TERM) begin
            gap_d = gap_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end

    // A byte arriving in the terminal cycle wins over the expiry.
    assign expired = enable && !clear && (gap_q == TERM);

endmodule

// File: rtl/iram_loader.sv
// Framed byte-stream loader driving the instruction RAM write port and CPU hold.
// Optional trailing checksum byte is enabled by defining IRAM_LOADER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | waiting for sync byte, other bytes ignored
// ADDR_H | expecting start address high byte
// ADDR_L | expecting start address low byte
// CNT_H  | expecting word count high byte
// CNT_L  | expecting word count low byte
// DATA_H | expecting high byte of next word
// DATA_L | expecting low byte of next word, issues the write
// CSUM   | expecting checksum byte (checksum build only)
module iram_loader
    import iram_loader_pkg::*;
#(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] w_addr,
    output logic [15:0]       din,
    output logic              w_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        ahi_q, ahi_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [15:0]       din_q, din_d;
    logic              w_en_q, w_en_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              hold_q, hold_d;
    logic              last_byte;
    logic              tmo_expired;
`ifdef IRAM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        csum_sum;
`endif

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_valid),
        .enable (state_q != ST_IDLE),
        .expired(tmo_expired)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ahi_d     = ahi_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        w_addr_d  = w_addr_q;
        din_d     = din_q;
        w_en_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;
        hold_d    = hold_q;
        last_byte = 1'b0;
`ifdef IRAM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
        csum_sum  = csum_add(csum_q, rx_data);
`endif

        if (tmo_expired) begin
            // cpu_hold is left asserted so a half-loaded image never runs.
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end else if (rx_valid) begin
`ifdef IRAM_LOADER_CHECKSUM_EN
            if (state_q != ST_IDLE && state_q != ST_CSUM) begin
                csum_d = csum_sum;
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        err_d   = 1'b0;
                        hold_d  = 1'b1;
                        state_d = ST_ADDR_H;
`ifdef IRAM_LOADER_CHECKSUM_EN
                        csum_d  = 8'h00;
`endif
                    end
                end
                ST_ADDR_H: begin
                    ahi_d   = rx_data;
                    state_d = ST_ADDR_L;
                end
                ST_ADDR_L: begin
                    addr_d  = ADDR_W'({ahi_q, rx_data});
                    state_d = ST_CNT_H;
                end
                ST_CNT_H: begin
                    cnt_d   = {rx_data, 8'h00};
                    state_d = ST_CNT_L;
                end
                ST_CNT_L: begin
                    cnt_d = {cnt_q[15:8], rx_data};
                    if ({cnt_q[15:8], rx_data} == 16'h0000) begin
                        last_byte = 1'b1;
                    end else begin
                        state_d = ST_DATA_H;
                    end
                end
                ST_DATA_H: begin
                    hi_d    = rx_data;
                    state_d = ST_DATA_L;
                end
                ST_DATA_L: begin
                    w_en_d   = 1'b1;
                    w_addr_d = addr_q;
                    din_d    = {hi_q, rx_data};
                    addr_d   = addr_q + ADDR_W'(1);
                    cnt_d    = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        last_byte = 1'b1;
                    end else begin
                        state_d = ST_DATA_H;
                    end
                end
`ifdef IRAM_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    state_d = ST_IDLE;
                    if (csum_sum == 8'h00) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        err_d  = 1'b1;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase

            if (last_byte) begin
`ifdef IRAM_LOADER_CHECKSUM_EN
                state_d = ST_CSUM;
`else
                state_d = ST_IDLE;
                done_d  = 1'b1;
                hold_d  = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            ahi_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            w_addr_q <= '0;
            din_q    <= '0;
            w_en_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            hold_q   <= 1'b0;
`ifdef IRAM_LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            ahi_q    <= ahi_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            w_addr_q <= w_addr_d;
            din_q    <= din_d;
            w_en_q   <= w_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            hold_q   <= hold_d;
`ifdef IRAM_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign w_addr   = w_addr_q;
    assign din      = din_q;
    assign w_en     = w_en_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign cpu_hold = hold_q;

endmodule

// File: tb/tb_iram_loader.sv
// Directed self-checking bench for iram_loader; checksum cases compile in with IRAM_LOADER_CHECKSUM_EN.
module tb_iram_loader;

    localparam int AW  = 16;
    localparam int TMO = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [AW-1:0] w_addr;
    logic [15:0]   din;
    logic          w_en;
    logic          busy;
    logic          done;
    logic          err;
    logic          cpu_hold;

    int total = 0;
    int bad   = 0;

    logic [15:0] log_addr[$];
    logic [15:0] log_data[$];
    int          done_seen = 0;
    int          hold_viol = 0;
    logic [7:0]  tx_q[$];

    always #5 clk = ~clk;

    iram_loader #(
        .ADDR_W(AW),
        .TIMEOUT_CYCLES(TMO),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .w_addr  (w_addr),
        .din     (din),
        .w_en    (w_en),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .cpu_hold(cpu_hold)
    );

    always @(negedge clk) begin
        if (w_en) begin
            log_addr.push_back(w_addr);
            log_data.push_back(din);
        end
        if (done) done_seen++;
        if (busy && !cpu_hold) hold_viol++;
        if (done && cpu_hold) hold_viol++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_range(input int from, input int upto, input int gap);
        for (int i = from; i < upto; i++) begin
            send_byte(tx_q[i]);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic frame_start(input logic [15:0] a, input logic [15:0] c);
        tx_q.delete();
        tx_q.push_back(8'hA5);
        tx_q.push_back(a[15:8]);
        tx_q.push_back(a[7:0]);
        tx_q.push_back(c[15:8]);
        tx_q.push_back(c[7:0]);
    endtask

    task automatic frame_word(input logic [15:0] w);
        tx_q.push_back(w[15:8]);
        tx_q.push_back(w[7:0]);
    endtask

    task automatic frame_end();
`ifdef IRAM_LOADER_CHECKSUM_EN
        logic [7:0] s;
        s = 8'h00;
        for (int i = 1; i < tx_q.size(); i++) s = s + tx_q[i];
        tx_q.push_back(8'h00 - s);
`endif
    endtask

    task automatic test_reset();
        idle(2);
        total++;
        if ({w_addr, din} !== 32'h0) begin
            bad++;
            $display("FAIL reset_addr_data: got %h/%h want 0000/0000", w_addr, din);
        end
        total++;
        if ({w_en, busy, done, err, cpu_hold} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000", {w_en, busy, done, err, cpu_hold});
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_idle_junk();
        int b0, d0;
        b0 = log_addr.size();
        d0 = done_seen;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        idle(2);
        total++;
        if ({w_addr, din, w_en, busy, done, err, cpu_hold} !== 37'h0 || log_addr.size() != b0) begin
            bad++;
            $display("FAIL junk_ignored: got addr=%h din=%h flags=%b writes=%0d want all zero, 0 writes",
                     w_addr, din, {w_en, busy, done, err, cpu_hold}, log_addr.size() - b0);
        end
        frame_start(16'h0010, 16'd2);
        frame_word(16'h1234);
        frame_word(16'hABCD);
        frame_end();
        send_range(0, tx_q.size(), 0);
        idle(3);
        total++;
        if (log_addr.size() != b0 + 2) begin
            bad++;
            $display("FAIL junk_write_count: got %0d want 2", log_addr.size() - b0);
        end else begin
            total++;
            if (log_addr[b0] !== 16'h0010 || log_data[b0] !== 16'h1234) begin
                bad++;
                $display("FAIL junk_write0: got %h:%h want 0010:1234", log_addr[b0], log_data[b0]);
            end
            total++;
            if (log_addr[b0+1] !== 16'h0011 || log_data[b0+1] !== 16'hABCD) begin
                bad++;
                $display("FAIL junk_write1: got %h:%h want 0011:abcd", log_addr[b0+1], log_data[b0+1]);
            end
        end
        total++;
        if (done_seen - d0 != 1 || cpu_hold !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL junk_finish: got done=%0d hold=%b busy=%b err=%b want 1 0 0 0",
                     done_seen - d0, cpu_hold, busy, err);
        end
    endtask

    task automatic test_gapped();
        int b0, d0;
        logic [15:0] ed[3];
        ed = '{16'h0001, 16'h8000, 16'hFFFF};
        b0 = log_addr.size();
        d0 = done_seen;
        frame_start(16'h0200, 16'd3);
        for (int i = 0; i < 3; i++) frame_word(ed[i]);
        frame_end();
        send_range(0, tx_q.size(), 2);
        idle(3);
        total++;
        if (log_addr.size() != b0 + 3) begin
            bad++;
            $display("FAIL gapped_write_count: got %0d want 3", log_addr.size() - b0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (log_addr[b0+i] !== 16'h0200 + 16'(i) || log_data[b0+i] !== ed[i]) begin
                    bad++;
                    $display("FAIL gapped_write%0d: got %h:%h want %h:%h", i, log_addr[b0+i],
                             log_data[b0+i], 16'h0200 + 16'(i), ed[i]);
                end
            end
        end
        total++;
        if (done_seen - d0 != 1 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL gapped_done: got done=%0d hold=%b want 1 0", done_seen - d0, cpu_hold);
        end
    endtask

    task automatic test_zero_count();
        int b0, d0;
        b0 = log_addr.size();
        d0 = done_seen;
        frame_start(16'h0000, 16'd0);
        frame_end();
        send_range(0, tx_q.size(), 0);
        idle(3);
        total++;
        if (log_addr.size() != b0 || done_seen - d0 != 1 || cpu_hold !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL zero_count: got writes=%0d done=%0d hold=%b err=%b want 0 1 0 0",
                     log_addr.size() - b0, done_seen - d0, cpu_hold, err);
        end
    endtask

    task automatic test_wrap();
        int b0;
        b0 = log_addr.size();
        frame_start(16'hFFFF, 16'd2);
        frame_word(16'hCAFE);
        frame_word(16'h0BAD);
        frame_end();
        send_range(0, tx_q.size(), 0);
        idle(3);
        total++;
        if (log_addr.size() != b0 + 2) begin
            bad++;
            $display("FAIL wrap_write_count: got %0d want 2", log_addr.size() - b0);
        end else begin
            total++;
            if (log_addr[b0] !== 16'hFFFF || log_data[b0] !== 16'hCAFE ||
                log_addr[b0+1] !== 16'h0000 || log_data[b0+1] !== 16'h0BAD) begin
                bad++;
                $display("FAIL wrap_writes: got %h:%h %h:%h want ffff:cafe 0000:0bad",
                         log_addr[b0], log_data[b0], log_addr[b0+1], log_data[b0+1]);
            end
        end
    endtask

    task automatic test_latency();
        int d0;
        d0 = done_seen;
        frame_start(16'h0030, 16'd1);
        frame_word(16'hAA55);
        frame_end();
        send_range(0, 6, 0);
        rx_data  = tx_q[6];
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (w_en !== 1'b1 || w_addr !== 16'h0030 || din !== 16'hAA55) begin
            bad++;
            $display("FAIL latency_write: got w_en=%b %h:%h want 1 0030:aa55", w_en, w_addr, din);
        end
`ifndef IRAM_LOADER_CHECKSUM_EN
        total++;
        if (done !== 1'b1 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL latency_done: got done=%b hold=%b want 1 0", done, cpu_hold);
        end
`endif
        @(negedge clk);
        rx_valid = 1'b0;
        idle(1);
        total++;
        if (w_en !== 1'b0) begin
            bad++;
            $display("FAIL latency_single_pulse: got w_en=%b want 0", w_en);
        end
        send_range(7, tx_q.size(), 0);
        idle(3);
        total++;
        if (done_seen - d0 != 1 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL latency_finish: got done=%0d hold=%b want 1 0", done_seen - d0, cpu_hold);
        end
    endtask

    task automatic test_timeout_boundary();
        int b0, d0;
        b0 = log_addr.size();
        d0 = done_seen;
        frame_start(16'h0050, 16'd1);
        frame_word(16'h1234);
        frame_end();
        send_range(0, 3, 0);
        idle(TMO - 1);
        send_range(3, tx_q.size(), 0);
        idle(3);
        total++;
        if (err !== 1'b0 || done_seen - d0 != 1 || log_addr.size() != b0 + 1) begin
            bad++;
            $display("FAIL tmo_byte_wins: got err=%b done=%0d writes=%0d want 0 1 1",
                     err, done_seen - d0, log_addr.size() - b0);
        end else begin
            total++;
            if (log_addr[b0] !== 16'h0050 || log_data[b0] !== 16'h1234) begin
                bad++;
                $display("FAIL tmo_byte_wins_write: got %h:%h want 0050:1234", log_addr[b0], log_data[b0]);
            end
        end
    endtask

    task automatic test_timeout();
        int b0, d0;
        d0 = done_seen;
        send_byte(8'hA5);
        total++;
        if (cpu_hold !== 1'b1 || busy !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL tmo_after_sync: got hold=%b busy=%b err=%b want 1 1 0", cpu_hold, busy, err);
        end
        send_byte(8'h00);
        send_byte(8'h10);
        idle(TMO - 1);
        total++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL tmo_not_yet: got busy=%b err=%b want 1 0", busy, err);
        end
        idle(1);
        total++;
        if (err !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL tmo_expired: got err=%b busy=%b hold=%b want 1 0 1", err, busy, cpu_hold);
        end
        idle(5);
        total++;
        if (err !== 1'b1 || cpu_hold !== 1'b1 || done_seen != d0) begin
            bad++;
            $display("FAIL tmo_sticky: got err=%b hold=%b done=%0d want 1 1 0", err, cpu_hold, done_seen - d0);
        end
        b0 = log_addr.size();
        frame_start(16'h0040, 16'd1);
        frame_word(16'hBEEF);
        frame_end();
        send_range(0, 1, 0);
        total++;
        if (err !== 1'b0 || cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL tmo_sync_clears_err: got err=%b hold=%b want 0 1", err, cpu_hold);
        end
        send_range(1, tx_q.size(), 0);
        idle(3);
        total++;
        if (done_seen - d0 != 1 || cpu_hold !== 1'b0 || log_addr.size() != b0 + 1) begin
            bad++;
            $display("FAIL tmo_recover: got done=%0d hold=%b writes=%0d want 1 0 1",
                     done_seen - d0, cpu_hold, log_addr.size() - b0);
        end else begin
            total++;
            if (log_addr[b0] !== 16'h0040 || log_data[b0] !== 16'hBEEF) begin
                bad++;
                $display("FAIL tmo_recover_write: got %h:%h want 0040:beef", log_addr[b0], log_data[b0]);
            end
        end
    endtask

`ifdef IRAM_LOADER_CHECKSUM_EN
    task automatic test_bad_csum();
        int b0, d0;
        b0 = log_addr.size();
        d0 = done_seen;
        frame_start(16'h0010, 16'd2);
        frame_word(16'h1234);
        frame_word(16'hABCD);
        frame_end();
        total++;
        if (tx_q[tx_q.size()-1] !== 8'h30) begin
            bad++;
            $display("FAIL csum_value: got %h want 30", tx_q[tx_q.size()-1]);
        end
        tx_q[tx_q.size()-1] = tx_q[tx_q.size()-1] + 8'h01;
        send_range(0, tx_q.size(), 0);
        idle(3);
        total++;
        if (log_addr.size() != b0 + 2 || err !== 1'b1 || done_seen != d0 ||
            cpu_hold !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL csum_bad: got writes=%0d err=%b done=%0d hold=%b busy=%b want 2 1 0 1 0",
                     log_addr.size() - b0, err, done_seen - d0, cpu_hold, busy);
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        int b0;
        b0 = log_addr.size();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h60);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h11);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({w_addr, din, w_en, busy, done, err, cpu_hold} !== 37'h0) begin
            bad++;
            $display("FAIL midrst_outputs: got addr=%h din=%h flags=%b want all zero",
                     w_addr, din, {w_en, busy, done, err, cpu_hold});
        end
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        frame_start(16'h0070, 16'd1);
        frame_word(16'h2233);
        frame_end();
        send_range(0, tx_q.size(), 0);
        idle(3);
        total++;
        if (log_addr.size() != b0 + 1) begin
            bad++;
            $display("FAIL midrst_write_count: got %0d want 1", log_addr.size() - b0);
        end else begin
            total++;
            if (log_addr[b0] !== 16'h0070 || log_data[b0] !== 16'h2233 || cpu_hold !== 1'b0) begin
                bad++;
                $display("FAIL midrst_reload: got %h:%h hold=%b want 0070:2233 0",
                         log_addr[b0], log_data[b0], cpu_hold);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        test_reset();
        test_idle_junk();
        test_gapped();
        test_zero_count();
        test_wrap();
        test_latency();
        test_timeout_boundary();
        test_timeout();
`ifdef IRAM_LOADER_CHECKSUM_EN
        test_bad_csum();
`endif
        test_reset_mid_frame();
        total++;
        if (hold_viol != 0) begin
            bad++;
            $display("FAIL hold_consistency: got %0d violating cycles want 0", hold_viol);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
